// File: rtl/clk_rst_seq.sv
// clk_rst_seq: power-up/recovery sequencer for the Clk_25M clock manager.
// It pulses Dcm_Reset, qualifies Locked, releases Sys_Reset, and retries or fails on lock timeout.
// Optional feature: define LOCK_LOSS_CNT_EN to count S_RUN lock losses on Loss_Cnt.
module clk_rst_seq #(
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_STABLE  = 64,
    parameter int LOCK_TIMEOUT = 65536,
    parameter int SYS_HOLD     = 32,
    parameter int MAX_RETRY    = 3,
    parameter int CNT_W        = 17
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Locked,
    input  logic       Restart,
    output logic       Dcm_Reset,
    output logic       Sys_Reset,
    output logic       Ready,
    output logic       Fail,
    output logic [7:0] Retry_Cnt,
    output logic [7:0] Loss_Cnt
);
    localparam int STAB_W = $clog2(LOCK_STABLE + 1);

    typedef enum logic [2:0] {S_RST, S_WAIT, S_HOLD, S_RUN, S_FAIL} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [STAB_W-1:0]  stab_q, stab_d;
    logic [7:0]         retry_q, retry_d;
    logic               sync1_q, lock_s_q;
    logic               dcm_q, dcm_d, sys_q, sys_d, ready_q, ready_d, fail_q, fail_d;

    // Next-state and counter logic; every state change clears the per-state counters.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        stab_d  = '0;
        retry_d = retry_q;
        case (state_q)
            S_RST: if (cnt_q == CNT_W'(RST_CYCLES - 1)) state_d = S_WAIT;
            S_WAIT: begin
                stab_d = lock_s_q ? stab_q + 1'b1 : '0;
                if (lock_s_q && stab_q == STAB_W'(LOCK_STABLE - 1)) begin
                    state_d = S_HOLD;
                end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    state_d = (retry_q == 8'(MAX_RETRY)) ? S_FAIL : S_RST;
                    retry_d = (retry_q == 8'(MAX_RETRY)) ? retry_q : retry_q + 8'd1;
                end
            end
            S_HOLD: begin
                if (!lock_s_q) begin
                    state_d = S_RST;
                end else if (cnt_q == CNT_W'(SYS_HOLD - 1)) begin
                    state_d = S_RUN;
                    retry_d = '0;
                end
            end
            S_RUN: if (!lock_s_q) state_d = S_RST;
            S_FAIL: begin
                if (Restart) begin
                    state_d = S_RST;
                    retry_d = '0;
                end
            end
            default: state_d = S_RST;
        endcase
        if (state_d != state_q) begin
            cnt_d  = '0;
            stab_d = '0;
        end
        dcm_d   = (state_d == S_RST) || (state_d == S_FAIL);
        sys_d   = state_d != S_RUN;
        ready_d = state_d == S_RUN;
        fail_d  = state_d == S_FAIL;
    end

    // State, counters, Locked synchronizer and registered outputs.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= S_RST;
            cnt_q    <= '0;
            stab_q   <= '0;
            retry_q  <= '0;
            sync1_q  <= 1'b0;
            lock_s_q <= 1'b0;
            dcm_q    <= 1'b1;
            sys_q    <= 1'b1;
            ready_q  <= 1'b0;
            fail_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            stab_q   <= stab_d;
            retry_q  <= retry_d;
            sync1_q  <= Locked;
            lock_s_q <= sync1_q;
            dcm_q    <= dcm_d;
            sys_q    <= sys_d;
            ready_q  <= ready_d;
            fail_q   <= fail_d;
        end
    end

    assign Dcm_Reset = dcm_q;
    assign Sys_Reset = sys_q;
    assign Ready     = ready_q;
    assign Fail      = fail_q;
    assign Retry_Cnt = retry_q;

`ifdef LOCK_LOSS_CNT_EN
    logic [7:0] loss_q, loss_d;

    // Saturating count of lock losses seen while running.
    always_comb begin
        loss_d = (state_q == S_RUN && state_d == S_RST && loss_q != 8'hFF) ? loss_q + 8'd1 : loss_q;
    end

    // Loss counter register, cleared only by Reset.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) loss_q <= '0;
        else       loss_q <= loss_d;
    end

    assign Loss_Cnt = loss_q;
`else
    assign Loss_Cnt = 8'd0;
`endif
endmodule

// File: tb/tb_clk_rst_seq.sv
// tb_clk_rst_seq: vector table, hand-written corner sequences and a randomized run against a reference model.
module tb_clk_rst_seq;
    localparam int RC = 4, LS = 8, LT = 100, SH = 5, MR = 2;
`ifdef LOCK_LOSS_CNT_EN
    localparam bit LC_EN = 1'b1;
`else
    localparam bit LC_EN = 1'b0;
`endif
    localparam int P_RST = 0, P_WAIT = 1, P_HOLD = 2, P_RUN = 3, P_FAIL = 4;

    logic       Clk = 1'b0, Reset = 1'b1, Locked = 1'b1, Restart = 1'b0;
    logic       Dcm_Reset, Sys_Reset, Ready, Fail;
    logic [7:0] Retry_Cnt, Loss_Cnt;
    int         checks = 0, failures = 0;

    typedef struct {
        bit rst, lk, rs;
        int n;
        bit d, s, r, f;
        int rt, ls;
    } vec_t;
    vec_t tbl[$];

    int m_ph, m_time, m_stab, m_retry, m_loss;
    bit lk_pipe[$];

    clk_rst_seq #(.RST_CYCLES(RC), .LOCK_STABLE(LS), .LOCK_TIMEOUT(LT), .SYS_HOLD(SH),
                  .MAX_RETRY(MR), .CNT_W(17)) dut (
        .Clk(Clk), .Reset(Reset), .Locked(Locked), .Restart(Restart),
        .Dcm_Reset(Dcm_Reset), .Sys_Reset(Sys_Reset), .Ready(Ready), .Fail(Fail),
        .Retry_Cnt(Retry_Cnt), .Loss_Cnt(Loss_Cnt));

    always #5 Clk = ~Clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    function automatic logic [19:0] outs();
        return {Dcm_Reset, Sys_Reset, Ready, Fail, Retry_Cnt, Loss_Cnt};
    endfunction

    function automatic logic [19:0] ev(bit d, bit s, bit r, bit f, int rt, int ls);
        return {d, s, r, f, 8'(rt), 8'(ls)};
    endfunction

    task automatic check(string nm, logic [19:0] exp);
        checks++;
        if (outs() !== exp) begin
            failures++;
            $display("FAIL %s: dcm,sys,rdy,fail,retry,loss got %b,%b,%b,%b,%0d,%0d want %b,%b,%b,%b,%0d,%0d",
                     nm, Dcm_Reset, Sys_Reset, Ready, Fail, Retry_Cnt, Loss_Cnt,
                     exp[19], exp[18], exp[17], exp[16], exp[15:8], exp[7:0]);
        end
    endtask

    task automatic check_int(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic enter(int ph);
        m_ph = ph;
        m_time = 0;
        m_stab = 0;
    endtask

    task automatic model_reset();
        enter(P_RST);
        m_retry = 0;
        m_loss = 0;
        lk_pipe = '{1'b0, 1'b0};
    endtask

    // One clock edge of the sequencer rules; Locked is seen two edges late.
    task automatic step_model();
        bit ls;
        if (Reset) begin
            model_reset();
            return;
        end
        ls = lk_pipe.pop_front();
        lk_pipe.push_back(Locked);
        m_time++;
        case (m_ph)
            P_RST: if (m_time == RC) enter(P_WAIT);
            P_WAIT: begin
                m_stab = ls ? m_stab + 1 : 0;
                if (m_stab == LS) enter(P_HOLD);
                else if (m_time == LT) begin
                    if (m_retry == MR) enter(P_FAIL);
                    else begin
                        m_retry++;
                        enter(P_RST);
                    end
                end
            end
            P_HOLD: begin
                if (!ls) enter(P_RST);
                else if (m_time == SH) begin
                    m_retry = 0;
                    enter(P_RUN);
                end
            end
            P_RUN: begin
                if (!ls) begin
                    if (LC_EN && m_loss < 255) m_loss++;
                    enter(P_RST);
                end
            end
            default: begin
                if (Restart) begin
                    m_retry = 0;
                    enter(P_RST);
                end
            end
        endcase
    endtask

    function automatic logic [19:0] m_exp();
        return ev(m_ph == P_RST || m_ph == P_FAIL, m_ph != P_RUN, m_ph == P_RUN, m_ph == P_FAIL,
                  m_retry, m_loss);
    endfunction

    task automatic tick();
        step_model();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        Restart = 1'b0;
        tick();
        tick();
        Reset = 1'b0;
    endtask

    initial begin
        int lc1, k, lowc, sysl, rdyc, seg;
        model_reset();
        lc1 = LC_EN ? 1 : 0;
        tbl.push_back('{1, 1, 0,   2, 1, 1, 0, 0, 0, 0});
        tbl.push_back('{0, 1, 0,   3, 1, 1, 0, 0, 0, 0});
        tbl.push_back('{0, 1, 0,   1, 0, 1, 0, 0, 0, 0});
        tbl.push_back('{0, 1, 0,   7, 0, 1, 0, 0, 0, 0});
        tbl.push_back('{0, 1, 0,   1, 0, 1, 0, 0, 0, 0});
        tbl.push_back('{0, 1, 0,   4, 0, 1, 0, 0, 0, 0});
        tbl.push_back('{0, 1, 0,   1, 0, 0, 1, 0, 0, 0});
        tbl.push_back('{0, 0, 0,   2, 0, 0, 1, 0, 0, 0});
        tbl.push_back('{0, 0, 0,   1, 1, 1, 0, 0, 0, lc1});
        tbl.push_back('{0, 0, 0,   4, 0, 1, 0, 0, 0, lc1});
        tbl.push_back('{0, 0, 0,  99, 0, 1, 0, 0, 0, lc1});
        tbl.push_back('{0, 0, 0,   1, 1, 1, 0, 0, 1, lc1});
        tbl.push_back('{0, 0, 0, 104, 1, 1, 0, 0, 2, lc1});
        tbl.push_back('{0, 0, 0, 104, 1, 1, 0, 1, 2, lc1});
        tbl.push_back('{0, 1, 0,  20, 1, 1, 0, 1, 2, lc1});
        tbl.push_back('{0, 0, 1,   1, 1, 1, 0, 0, 0, lc1});
        tbl.push_back('{0, 0, 0,   3, 1, 1, 0, 0, 0, lc1});
        tbl.push_back('{0, 0, 0,   1, 0, 1, 0, 0, 0, lc1});
        foreach (tbl[i]) begin
            Reset = tbl[i].rst;
            Locked = tbl[i].lk;
            Restart = tbl[i].rs;
            repeat (tbl[i].n) tick();
            check($sformatf("vec%0d", i), ev(tbl[i].d, tbl[i].s, tbl[i].r, tbl[i].f, tbl[i].rt, tbl[i].ls));
        end
        Restart = 1'b0;

        // Locked rising only once the manager leaves reset adds the synchronizer latency.
        Locked = 1'b0;
        do_reset();
        k = 0;
        repeat (RC) begin
            tick();
            k++;
        end
        Locked = 1'b1;
        while (!Ready && k < 60) begin
            tick();
            k++;
        end
        check_int("relock_ready_latency", k, RC + 2 + LS + SH);

        // 5 high / 1 low glitching never qualifies lock and times out.
        do_reset();
        lowc = 0;
        sysl = 0;
        for (int j = 0; j < RC + LT; j++) begin
            Locked = (j % 6) != 5;
            tick();
            if (!Dcm_Reset) lowc++;
            if (!Sys_Reset) sysl++;
        end
        check_int("glitch_wait_cycles", lowc, LT);
        check_int("glitch_sys_low_cycles", sysl, 0);
        check("glitch_timeout", ev(1, 1, 0, 0, 1, 0));

        // One-cycle lock drop in S_RUN: Sys_Reset after 3 edges, then full re-sequence.
        do_reset();
        Locked = 1'b1;
        repeat (RC + LS + SH) tick();
        check("run_reached", ev(0, 0, 1, 0, 0, 0));
        Locked = 1'b0;
        k = 0;
        while (!Sys_Reset && k < 10) begin
            tick();
            Locked = 1'b1;
            k++;
        end
        check_int("loss_sys_latency", k, 3);
        k = 0;
        while (!Ready && k < 60) begin
            tick();
            k++;
        end
        check_int("resequence_latency", k, RC + LS + SH);
        check("resequence_run", ev(0, 0, 1, 0, 0, lc1));

        // Lock lost during S_HOLD goes back to S_RST without Ready.
        do_reset();
        Locked = 1'b1;
        repeat (RC + LS + 1) tick();
        Locked = 1'b0;
        k = 0;
        rdyc = 0;
        for (int j = 1; j <= 30; j++) begin
            tick();
            if (Ready) rdyc++;
            if (Dcm_Reset && k == 0) k = j;
        end
        check_int("hold_loss_dcm_edge", k, 3);
        check_int("hold_loss_ready_pulses", rdyc, 0);

        // Asynchronous reset in S_HOLD, then a clean restart.
        do_reset();
        Locked = 1'b1;
        repeat (RC + LS + 2) tick();
        #2;
        Reset = 1'b1;
        #1;
        check("async_rst_hold", ev(1, 1, 0, 0, 0, 0));
        tick();
        Reset = 1'b0;
        k = 0;
        while (!Ready && k < 60) begin
            tick();
            k++;
        end
        check_int("restart_after_hold_rst", k, RC + LS + SH);

        // Lose lock from S_RUN, time out into S_FAIL, then reset asynchronously.
        Locked = 1'b0;
        k = 0;
        while (!Fail && k < 500) begin
            tick();
            k++;
        end
        check_int("fail_reached_edge", k, 3 + 3 * (RC + LT));
        check("fail_state", ev(1, 1, 0, 1, MR, lc1));
        #2;
        Reset = 1'b1;
        #1;
        check("async_rst_fail", ev(1, 1, 0, 0, 0, 0));
        tick();
        Reset = 1'b0;
        Locked = 1'b1;
        k = 0;
        while (!Ready && k < 60) begin
            tick();
            k++;
        end
        check_int("restart_after_fail_rst", k, RC + LS + SH);

        // Randomized stimulus against the reference model.
        do_reset();
        seg = 0;
        for (int i = 0; i < 4000; i++) begin
            if (seg == 0) begin
                if ($urandom_range(0, 7) == 0) begin
                    Locked = 1'b0;
                    seg = int'($urandom_range(90, 330));
                end else begin
                    Locked = 1'($urandom_range(0, 1));
                    seg = Locked ? int'($urandom_range(1, 40)) : int'($urandom_range(1, 6));
                end
            end
            seg--;
            Restart = ($urandom_range(0, 19) == 0);
            Reset = ($urandom_range(0, 1499) == 0);
            tick();
            check($sformatf("rand%0d", i), m_exp());
        end
        Reset = 1'b0;
        Restart = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
